// File: rtl/wb_axis_in_fifo.sv
// rtl/wb_axis_in_fifo.sv - Wishbone-fed input FIFO driving an AXI-Stream master
//
// Purpose: the CPU pushes X[n] samples through a Wishbone slave port into a
// small first-word-fall-through FIFO, which streams them toward the FIR.
// Frames are delimited by ap_start and data_length; tlast marks the final
// sample of a frame and frame_done reports its completion.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i      Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]            byte selects (only full-word pushes are stored)
//   wbs_adr_i, wbs_dat_i      address (bits [7:0] decoded) and write data
//   wbs_ack_o, wbs_dat_o      one-cycle acknowledge and read data
//   ap_start, data_length     frame start pulse and sample count
//   ss_tdata/tvalid/tlast     stream master outputs
//   ss_tready                 stream consumer ready
module wb_axis_in_fifo #(
   parameter int pDATA_WIDTH = 32,
   parameter int pDEPTH      = 4
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_we_i,
   input  logic [3:0]             wbs_sel_i,
   input  logic [31:0]            wbs_dat_i,
   input  logic [31:0]            wbs_adr_i,
   output logic                   wbs_ack_o,
   output logic [31:0]            wbs_dat_o,
   input  logic                   ap_start,
   input  logic [31:0]            data_length,
   output logic                   ss_tvalid,
   output logic [pDATA_WIDTH-1:0] ss_tdata,
   output logic                   ss_tlast,
   input  logic                   ss_tready
);

   localparam int AW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(pDEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK
   } state_t;

   state_t state, state_nx;

   logic [pDATA_WIDTH-1:0] mem [pDEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [CW-1:0]          count;
   logic                   empty, full;
   logic                   req, adr_push, adr_stat, push_wr;
   logic                   enter_ack, push, pop;
   logic [31:0]            last_push;
   logic [31:0]            beat_cnt, len_q;
   logic                   frame_done;
   logic [31:0]            status_word, rd_word;
   logic                   unused_adr;

   assign unused_adr = ^wbs_adr_i[31:8];

   assign req      = wbs_cyc_i & wbs_stb_i;
   assign adr_push = (wbs_adr_i[7:0] == 8'h80);
   assign adr_stat = (wbs_adr_i[7:0] == 8'h88);
   // Only a full-word write is a real push; partial writes are acked and dropped.
   assign push_wr  = wbs_we_i & adr_push & (wbs_sel_i == 4'hF);

   // Fullness comes from the registered count only, so a pop in the same
   // cycle never lets a push into a full FIFO.
   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);

   always_comb begin
      state_nx  = state;
      enter_ack = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (push_wr && full) begin
                  state_nx = ST_WAIT;
               end else begin
                  state_nx  = ST_ACK;
                  enter_ack = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            // An abandoned cycle leaves without pushing or acking.
            if (!wbs_cyc_i) begin
               state_nx = ST_IDLE;
            end else if (!full) begin
               state_nx  = ST_ACK;
               enter_ack = 1'b1;
            end
         end
         ST_ACK: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   assign push = enter_ack & push_wr;
   assign pop  = ~empty & ss_tready;

   always_ff @(posedge wb_clk_i) begin
      if (push && !wb_rst_i) begin
         mem[wr_ptr] <= pDATA_WIDTH'(wbs_dat_i);
      end
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_push <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + AW'(1);
            last_push <= wbs_dat_i;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign ss_tvalid = ~empty;
   assign ss_tdata  = empty ? '0 : mem[rd_ptr];
   // A zero length never matches because len_q - 1 would wrap; gate it explicitly.
   assign ss_tlast  = ss_tvalid & (len_q != 32'd0) & (beat_cnt == len_q - 32'd1);

   // ap_start takes priority over a beat accepted in the same cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         beat_cnt   <= '0;
         len_q      <= '0;
         frame_done <= 1'b0;
      end else if (ap_start) begin
         beat_cnt   <= '0;
         len_q      <= data_length;
         frame_done <= 1'b0;
      end else if (pop) begin
         if (ss_tlast) begin
            beat_cnt   <= '0;
            frame_done <= 1'b1;
         end else begin
            beat_cnt <= beat_cnt + 32'd1;
         end
      end
   end

   assign status_word = {24'd0, 5'(count), frame_done, full, empty};

   always_comb begin
      rd_word = 32'd0;
      if (adr_push) begin
         rd_word = last_push;
      end else if (adr_stat) begin
         rd_word = status_word;
      end
   end

   // Read data is captured on entry to ACK and is zero in every other cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_dat_o <= '0;
      end else if (enter_ack && !wbs_we_i) begin
         wbs_dat_o <= rd_word;
      end else begin
         wbs_dat_o <= '0;
      end
   end

   assign wbs_ack_o = (state == ST_ACK);

endmodule

// File: tb/tb_wb_axis_in_fifo.sv
// tb/tb_wb_axis_in_fifo.sv - randomized self-checking bench for wb_axis_in_fifo
module tb_wb_axis_in_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i;
   logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]    wbs_sel_i;
   logic [31:0]   wbs_dat_i, wbs_adr_i;
   logic          wbs_ack_o;
   logic [31:0]   wbs_dat_o;
   logic          ap_start;
   logic [31:0]   data_length;
   logic          ss_tvalid, ss_tlast, ss_tready;
   logic [DW-1:0] ss_tdata;

   wb_axis_in_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_sel_i   (wbs_sel_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_dat_o   (wbs_dat_o),
      .ap_start    (ap_start),
      .data_length (data_length),
      .ss_tvalid   (ss_tvalid),
      .ss_tdata    (ss_tdata),
      .ss_tlast    (ss_tlast),
      .ss_tready   (ss_tready)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of words the FIFO should hold, frame progress.
   logic [31:0] q[$];
   logic [31:0] m_beats, m_len, last_push;
   logic        m_fd;
   int          ready_mode;  // 0 low, 1 high, 2 random
   bit          mon_on;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      return {24'd0, 5'(q.size()), m_fd, (q.size() == DEPTH), (q.size() == 0)};
   endfunction

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit pop_with,
                          output logic [31:0] rdat, output int lat);
      int save;
      bit got;
      save = ready_mode;
      got  = 0;
      rdat = '0;
      lat  = 0;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
      wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
      if (pop_with) ready_mode = 1;
      while (!got && lat < 20) begin
         @(posedge wb_clk_i); #1;
         lat++;
         if (pop_with) ready_mode = save;
         if (wbs_ack_o) begin
            got  = 1;
            rdat = wbs_dat_o;
            if (we && adr[7:0] == 8'h80 && sel == 4'hF) begin
               q.push_back(dat);
               last_push = dat;
            end
         end
      end
      if (!got) check("ack_timeout", {31'd0, got}, 32'd1);
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      @(posedge wb_clk_i); #1;
      check("idle_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("idle_dat", wbs_dat_o, 32'd0);
   endtask

   task automatic ap_pulse(input logic [31:0] len);
      ap_start = 1; data_length = len;
      @(posedge wb_clk_i); #1;
      ap_start = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      ready_mode = 1;
      while (ss_tvalid && n < 100) begin
         @(posedge wb_clk_i); #1;
         n++;
      end
      check("drain_tvalid", {31'd0, ss_tvalid}, 32'd0);
      ready_mode = 0;
      @(posedge wb_clk_i); #1;
   endtask

   initial begin
      logic [31:0] rd, es, d;
      int          lat, r;
      bit          got;

      wb_rst_i = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
      wbs_dat_i = 0; wbs_adr_i = 0; ap_start = 0; data_length = 0; ss_tready = 0;
      ready_mode = 0; mon_on = 0; last_push = 0; m_beats = 0; m_len = 0; m_fd = 0;

      fork
         forever begin
            @(posedge wb_clk_i); #2;
            case (ready_mode)
               0:       ss_tready = 1'b0;
               1:       ss_tready = 1'b1;
               default: ss_tready = 1'($urandom_range(0, 1));
            endcase
         end
         forever begin : monitor
            logic exp_last;
            bit   acc;
            @(negedge wb_clk_i);
            if (wb_rst_i) begin
               q.delete(); m_beats = 0; m_len = 0; m_fd = 0; last_push = 0;
            end else if (mon_on) begin
               check("tvalid", {31'd0, ss_tvalid}, {31'd0, q.size() != 0});
               if (q.size() != 0) check("tdata", ss_tdata, q[0]);
               exp_last = (q.size() != 0) && (m_len != 0) && (m_beats == m_len - 1);
               check("tlast", {31'd0, ss_tlast}, {31'd0, exp_last});
               acc = (q.size() != 0) && ss_tready;
               if (ap_start) begin
                  m_beats = 0; m_len = data_length; m_fd = 0;
               end else if (acc) begin
                  if (exp_last) begin
                     m_beats = 0; m_fd = 1;
                  end else begin
                     m_beats = m_beats + 1;
                  end
               end
               if (acc) void'(q.pop_front());
            end
         end
      join_none

      repeat (2) @(posedge wb_clk_i);
      #1 wb_rst_i = 0;
      mon_on = 1;
      check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rst_dat", wbs_dat_o, 32'd0);
      check("rst_tvalid", {31'd0, ss_tvalid}, 32'd0);
      check("rst_tlast", {31'd0, ss_tlast}, 32'd0);
      check("rst_tdata", ss_tdata, 32'd0);
      wb_xfer(0, 32'h88, 0, 4'hF, 0, rd, lat);
      check("rst_status", rd, 32'h1);
      check("rd_lat", lat, 1);

      // Three-sample frame streamed straight through.
      ready_mode = 1;
      ap_pulse(3);
      for (int i = 1; i <= 3; i++) begin
         wb_xfer(1, 32'h80, 32'h11 * i, 4'hF, 0, rd, lat);
         check("push_lat", lat, 1);
      end
      drain();
      wb_xfer(0, 32'h88, 0, 4'hF, 0, rd, lat);
      check("frame_done", rd, 32'h5);

      // Fill with the consumer stalled; the fifth push waits for space.
      for (int i = 0; i < 4; i++) begin
         wb_xfer(1, 32'h80, 32'hA0 + i, 4'hF, 0, rd, lat);
         check("fill_lat", lat, 1);
      end
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
      wbs_adr_i = 32'h80; wbs_dat_i = 32'hA4; wbs_sel_i = 4'hF;
      repeat (4) begin
         @(posedge wb_clk_i); #1;
         check("wait_noack", {31'd0, wbs_ack_o}, 32'd0);
      end
      ready_mode = 1;
      lat = 0; got = 0;
      while (!got && lat < 10) begin
         @(posedge wb_clk_i); #1;
         lat++;
         ready_mode = 0;
         if (wbs_ack_o) begin
            got = 1;
            q.push_back(32'hA4);
            last_push = 32'hA4;
         end
      end
      check("stall_ack_lat", lat, 2);
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      @(posedge wb_clk_i); #1;
      es = exp_status();
      wb_xfer(0, 32'h88, 0, 4'hF, 0, rd, lat);
      check("full_status", rd, es);
      drain();

      // Two entries held, then push and pop in the same cycle three times.
      wb_xfer(1, 32'h80, 32'hB0, 4'hF, 0, rd, lat);
      wb_xfer(1, 32'h80, 32'hB1, 4'hF, 0, rd, lat);
      for (int i = 2; i < 5; i++) begin
         wb_xfer(1, 32'h80, 32'hB0 + i, 4'hF, 1, rd, lat);
         check("pp_lat", lat, 1);
      end
      es = exp_status();
      wb_xfer(0, 32'h88, 0, 4'hF, 0, rd, lat);
      check("pp_status", rd, es);
      check("pp_count", {27'd0, rd[7:3]}, 32'd2);
      drain();

      // Partial write, unmapped read, readback of last push.
      wb_xfer(1, 32'h80, 32'hDEAD, 4'h3, 0, rd, lat);
      check("sel3_lat", lat, 1);
      wb_xfer(0, 32'h88, 0, 4'hF, 0, rd, lat);
      check("sel3_count", {27'd0, rd[7:3]}, 32'd0);
      wb_xfer(0, 32'h44, 0, 4'hF, 0, rd, lat);
      check("unmapped_dat", rd, 32'd0);
      check("unmapped_lat", lat, 1);
      wb_xfer(0, 32'h80, 0, 4'hF, 0, rd, lat);
      check("last_push", rd, 32'hB4);

      // Zero-length frame: never tlast, frame_done stays low.
      ap_pulse(0);
      ready_mode = 1;
      wb_xfer(1, 32'h80, 32'hC0, 4'hF, 0, rd, lat);
      wb_xfer(1, 32'h80, 32'hC1, 4'hF, 0, rd, lat);
      drain();
      wb_xfer(0, 32'h88, 0, 4'hF, 0, rd, lat);
      check("len0_status", rd, 32'h1);

      // Random traffic with a random consumer.
      ready_mode = 2;
      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            ap_pulse($urandom_range(0, 4));
         end else if (r <= 2) begin
            es = last_push;
            wb_xfer(0, 32'h80, 0, 4'hF, 0, rd, lat);
            check("rnd_last", rd, es);
         end else if (r == 3) begin
            es = exp_status();
            wb_xfer(0, 32'h88, 0, 4'hF, 0, rd, lat);
            check("rnd_status", rd, es);
         end else begin
            d = $urandom;
            wb_xfer(1, 32'h80, d, 4'hF, 0, rd, lat);
         end
      end
      drain();

      // Reset while a push is stalled in WAIT.
      for (int i = 0; i < 4; i++) wb_xfer(1, 32'h80, 32'hE0 + i, 4'hF, 0, rd, lat);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
      wbs_adr_i = 32'h80; wbs_dat_i = 32'hE4; wbs_sel_i = 4'hF;
      repeat (3) begin
         @(posedge wb_clk_i); #1;
         check("wait2_noack", {31'd0, wbs_ack_o}, 32'd0);
      end
      wb_rst_i = 1;
      @(posedge wb_clk_i); #1;
      wb_rst_i = 0;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      check("rstw_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rstw_tvalid", {31'd0, ss_tvalid}, 32'd0);
      @(posedge wb_clk_i); #1;
      check("rstw_ack2", {31'd0, wbs_ack_o}, 32'd0);
      wb_xfer(0, 32'h88, 0, 4'hF, 0, rd, lat);
      check("rstw_status", rd, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
